match_controller: RTL and testbench

- Sequences a full pong match around the ball/paddle physics engine: idle, serve delay, play, point pause and game over.
- Generates the physics tick enable and the ball-reset strobe, chooses the serve direction, and keeps both scores and the winner.
- Sits between the button/switch inputs and the game-physics block.
- Its score outputs feed the on-screen digit renderers and the board seven-segment display.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/match_controller_tick_gen.sv | 32 +++
 rtl/match_controller.sv | 179 +++++++++++++++++
 tb/tb_match_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module : pong_pkg
// Brief  : Shared state, winner and serve-direction codes for the pong match.
// Rev    : 1.0
// ============================================================================
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic SERVE_RIGHT = 1'b1;
    localparam logic SERVE_LEFT  = 1'b0;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_controller_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : tick_gen
// Brief  : Free-running divider producing a one-cycle raw physics tick.
// Rev    : 1.0
// ============================================================================
module tick_gen #(
    parameter int TICK_CYCLES = 131072
) (
    input  logic board_clk,
    input  logic reset,
    output logic raw_tick
);

    localparam int              c_cw   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(TICK_CYCLES - 1);

    logic [c_cw-1:0] r_count;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (r_count == c_last)
            r_count <= '0;
        else
            r_count <= r_count + c_cw'(1);
    end

    assign raw_tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
// Module : match_controller
// Brief  : Pong match sequencer: serve/play/point/game-over, ticks and scores.
// Rev    : 1.0
// ============================================================================
module match_controller
    import pong_pkg::*;
#(
    parameter int TICK_CYCLES = 131072,
    parameter int SERVE_TICKS = 256,
    parameter int POINT_TICKS = 64,
    parameter int WIN_SCORE   = 9
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_sw,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic       tick,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    localparam int               c_dly_max = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int               c_dly_w   = $clog2(c_dly_max + 1);
    localparam logic [c_dly_w-1:0] c_serve = c_dly_w'(SERVE_TICKS);
    localparam logic [c_dly_w-1:0] c_point = c_dly_w'(POINT_TICKS);
    localparam logic [c_dly_w-1:0] c_one   = c_dly_w'(1);
    localparam logic [3:0]       c_win     = 4'(WIN_SCORE);

    logic r_start_meta, r_start_sync, r_start_prev;
    logic r_pause_meta, r_pause_sync;
    logic w_raw_tick, w_start_edge, w_step;

    state_t               r_state, w_state_nxt;
    logic [c_dly_w-1:0]   r_delay, w_delay_nxt;
    logic [3:0]           r_p1, w_p1, r_p2, w_p2;
    logic [1:0]           r_winner, w_winner;
    logic                 r_serve_dir, w_serve_dir;
    logic                 r_ball_reset, w_ball_reset_nxt;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
        .board_clk (board_clk),
        .reset     (reset),
        .raw_tick  (w_raw_tick)
    );

    // Start chain resets to "pressed" so a button held through reset release gives no edge.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_start_meta <= 1'b1;
            r_start_sync <= 1'b1;
            r_start_prev <= 1'b1;
            r_pause_meta <= 1'b0;
            r_pause_sync <= 1'b0;
        end else begin
            r_start_meta <= start_btn;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_pause_meta <= pause_sw;
            r_pause_sync <= r_pause_meta;
        end
    end

    assign w_start_edge = r_start_sync & ~r_start_prev;
    assign w_step       = w_raw_tick & ~r_pause_sync;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_delay      <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_winner     <= WIN_NONE;
            r_serve_dir  <= SERVE_RIGHT;
            r_ball_reset <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_delay      <= w_delay_nxt;
            r_p1         <= w_p1;
            r_p2         <= w_p2;
            r_winner     <= w_winner;
            r_serve_dir  <= w_serve_dir;
            r_ball_reset <= w_ball_reset_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_delay_nxt      = r_delay;
        w_p1             = r_p1;
        w_p2             = r_p2;
        w_winner         = r_winner;
        w_serve_dir      = r_serve_dir;
        w_ball_reset_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_p1     = '0;
                w_p2     = '0;
                w_winner = WIN_NONE;
                if (w_start_edge && !r_pause_sync) begin
                    w_state_nxt      = ST_SERVE;
                    w_delay_nxt      = c_serve;
                    w_serve_dir      = SERVE_RIGHT;
                    w_ball_reset_nxt = 1'b1;
                end
            end
            ST_SERVE: begin
                if (w_step) begin
                    if (r_delay == c_one)
                        w_state_nxt = ST_PLAY;
                    else
                        w_delay_nxt = r_delay - c_one;
                end
            end
            ST_PLAY: begin
                // A simultaneous double goal is treated as a void point.
                if (goal_p1 || goal_p2) begin
                    if (goal_p1 && !goal_p2) begin
                        w_p2        = sat_inc(r_p2);
                        w_serve_dir = SERVE_LEFT;
                    end else if (goal_p2 && !goal_p1) begin
                        w_p1        = sat_inc(r_p1);
                        w_serve_dir = SERVE_RIGHT;
                    end
                    w_state_nxt = ST_POINT;
                    w_delay_nxt = c_point;
                end
            end
            ST_POINT: begin
                if (w_step) begin
                    if (r_delay == c_one) begin
                        if (r_p1 == c_win) begin
                            w_state_nxt = ST_GAMEOVER;
                            w_winner    = WIN_P1;
                        end else if (r_p2 == c_win) begin
                            w_state_nxt = ST_GAMEOVER;
                            w_winner    = WIN_P2;
                        end else begin
                            w_state_nxt      = ST_SERVE;
                            w_delay_nxt      = c_serve;
                            w_ball_reset_nxt = 1'b1;
                        end
                    end else begin
                        w_delay_nxt = r_delay - c_one;
                    end
                end
            end
            ST_GAMEOVER: begin
                if (w_start_edge && !r_pause_sync) begin
                    w_p1             = '0;
                    w_p2             = '0;
                    w_winner         = WIN_NONE;
                    w_serve_dir      = SERVE_RIGHT;
                    w_state_nxt      = ST_SERVE;
                    w_delay_nxt      = c_serve;
                    w_ball_reset_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign tick       = w_raw_tick & (r_state == ST_PLAY) & ~r_pause_sync;
    assign ball_reset = r_ball_reset;
    assign serve_dir  = r_serve_dir;
    assign p1_score   = r_p1;
    assign p2_score   = r_p2;
    assign winner     = r_winner;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_match_controller
// Brief  : Directed + random stimulus against a behavioural match model.
// Rev    : 1.0
// ============================================================================
module tb_match_controller;

    localparam int TC = 4;
    localparam int ST = 3;
    localparam int PT = 2;
    localparam int WS = 3;

    logic       board_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_btn = 1'b0, pause_sw = 1'b0, goal_p1 = 1'b0, goal_p2 = 1'b0;
    logic       tick, ball_reset, serve_dir;
    logic [3:0] p1_score, p2_score;
    logic [1:0] winner;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_bad = 0;

    match_controller #(
        .TICK_CYCLES(TC), .SERVE_TICKS(ST), .POINT_TICKS(PT), .WIN_SCORE(WS)
    ) dut (
        .board_clk  (board_clk),
        .reset      (reset),
        .start_btn  (start_btn),
        .pause_sw   (pause_sw),
        .goal_p1    (goal_p1),
        .goal_p2    (goal_p2),
        .tick       (tick),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .winner     (winner),
        .state_o    (state_o)
    );

    always #5 board_clk = ~board_clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: phase 0..4, remaining ticks, divider position, input history.
    int m_div = 0, m_phase = 0, m_rem = 0, m_p1 = 0, m_p2 = 0, m_win = 0, m_dir = 1;
    bit m_br = 0, m_sm = 1, m_ss = 1, m_sp = 1, m_pm = 0, m_ps = 0;

    always @(posedge board_clk or posedge reset) begin
        bit raw, rise, paused, entered;
        if (reset) begin
            m_div = 0; m_phase = 0; m_rem = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1;
            m_br = 0; m_sm = 1; m_ss = 1; m_sp = 1; m_pm = 0; m_ps = 0;
        end else begin
            raw = (m_div == TC - 1); paused = m_ps; rise = m_ss && !m_sp; entered = 0;
            case (m_phase)
                0: begin
                    m_p1 = 0; m_p2 = 0; m_win = 0;
                    if (rise && !paused) begin m_phase = 1; m_rem = ST; m_dir = 1; entered = 1; end
                end
                1: if (raw && !paused) begin
                    if (m_rem == 1) m_phase = 2; else m_rem--;
                end
                2: if (goal_p1 || goal_p2) begin
                    if (goal_p1 && !goal_p2) begin m_p2 = (m_p2 == 15) ? 15 : m_p2 + 1; m_dir = 0; end
                    else if (goal_p2 && !goal_p1) begin m_p1 = (m_p1 == 15) ? 15 : m_p1 + 1; m_dir = 1; end
                    m_phase = 3; m_rem = PT;
                end
                3: if (raw && !paused) begin
                    if (m_rem == 1) begin
                        if (m_p1 == WS) begin m_phase = 4; m_win = 1; end
                        else if (m_p2 == WS) begin m_phase = 4; m_win = 2; end
                        else begin m_phase = 1; m_rem = ST; entered = 1; end
                    end else m_rem--;
                end
                4: if (rise && !paused) begin
                    m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1; m_phase = 1; m_rem = ST; entered = 1;
                end
                default: m_phase = 0;
            endcase
            m_br = entered;
            m_div = (m_div + 1) % TC;
            m_sp = m_ss; m_ss = m_sm; m_sm = start_btn;
            m_ps = m_pm; m_pm = pause_sw;
        end
    end

    always @(negedge board_clk) begin
        chk("tick", int'(tick), int'(m_div == TC - 1 && m_phase == 2 && !m_ps));
        chk("ball_reset", int'(ball_reset), int'(m_br));
        chk("serve_dir", int'(serve_dir), m_dir);
        chk("p1_score", int'(p1_score), m_p1);
        chk("p2_score", int'(p2_score), m_p2);
        chk("winner", int'(winner), m_win);
        chk("state", int'(state_o), m_phase);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge board_clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (int'(state_o) != s && n < budget) begin
            @(negedge board_clk);
            n++;
        end
        #1;
        chk(name, int'(state_o), s);
    endtask

    task automatic pulse_goal(input bit g1, input bit g2);
        goal_p1 = g1; goal_p2 = g2;
        cycles(1);
        goal_p1 = 1'b0; goal_p2 = 1'b0;
    endtask

    task automatic start_and_serve(input string name);
        start_btn = 1'b1;
        wait_state(1, 4, name);
        chk({name, "_ball_reset"}, int'(ball_reset), 1);
        start_btn = 1'b0;
    endtask

    initial begin
        int t;
        cycles(3);
        reset = 1'b0;
        cycles(2);
        chk("rst_state", int'(state_o), 0);
        chk("rst_serve_dir", int'(serve_dir), 1);
        chk("rst_scores", int'({p1_score, p2_score}), 0);

        // Start, serve countdown, play tick rate.
        start_and_serve("s1_serve");
        chk("s1_dir", int'(serve_dir), 1);
        wait_state(2, 16, "s1_play");
        t = 0;
        repeat (8) begin @(negedge board_clk); t += int'(tick); end
        #1;
        chk("s1_tick_rate", t, 2);

        // Held goal scores once.
        goal_p2 = 1'b1;
        cycles(12);
        goal_p2 = 1'b0;
        chk("s2_p1_once", int'(p1_score), 1);
        chk("s2_dir", int'(serve_dir), 1);
        wait_state(1, 20, "s2_serve");
        wait_state(2, 20, "s2_play");

        // Simultaneous goals: void point.
        pulse_goal(1'b1, 1'b1);
        chk("s3_state_point", int'(state_o), 3);
        chk("s3_scores", int'({p1_score, p2_score}), 16);
        wait_state(1, 20, "s3_serve");
        chk("s3_dir", int'(serve_dir), 1);
        wait_state(2, 20, "s3_play");

        // Three left-goal points end the match for P2.
        for (int i = 0; i < 3; i++) begin
            pulse_goal(1'b1, 1'b0);
            if (i < 2) begin
                wait_state(1, 20, "s4_serve");
                wait_state(2, 20, "s4_play");
            end
        end
        wait_state(4, 20, "s4_gameover");
        chk("s4_p2", int'(p2_score), 3);
        chk("s4_winner", int'(winner), 2);
        t = 0;
        repeat (8) begin @(negedge board_clk); t += int'(tick); end
        #1;
        chk("s4_no_tick", t, 0);
        start_and_serve("s4_restart");
        chk("s4_cleared", int'({p1_score, p2_score, 2'(winner)}), 0);

        // Pause freezes the serve countdown.
        pause_sw = 1'b1;
        cycles(40);
        chk("s5_frozen", int'(state_o), 1);
        pause_sw = 1'b0;
        wait_state(2, 20, "s5_play");

        // Random play.
        for (int i = 0; i < 3000; i++) begin
            start_btn = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 59) == 0) pause_sw = ~pause_sw;
            goal_p1 = ($urandom_range(0, 24) == 0);
            goal_p2 = ($urandom_range(0, 24) == 0);
            cycles(1);
        end
        start_btn = 1'b0; pause_sw = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;

        // Asynchronous reset mid-play.
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(4);
        start_and_serve("s6_serve");
        for (int i = 0; i < 2; i++) begin
            wait_state(2, 20, "s6_play");
            pulse_goal(1'b0, 1'b1);
            wait_state(1, 20, "s6_serve2");
        end
        wait_state(2, 20, "s6_play_final");
        chk("s6_p1_two", int'(p1_score), 2);
        start_btn = 1'b1;
        @(negedge board_clk);
        #2 reset = 1'b1;
        #1;
        chk("s6_async_state", int'(state_o), 0);
        chk("s6_async_p1", int'(p1_score), 0);
        chk("s6_async_dir", int'(serve_dir), 1);
        chk("s6_async_tick", int'({tick, ball_reset, 2'(winner)}), 0);
        cycles(3);
        reset = 1'b0;
        cycles(20);
        chk("s6_no_edge", int'(state_o), 0);
        start_btn = 1'b0;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
